// File: rtl/cereal_word_rx_pkg.sv
// Shared constants for the word receiver: ASCII codes, word ids,
// word lengths, letter tables and receiver FSM states.
package cereal_word_rx_pkg;

    localparam int CLKS_PER_BIT_DEF = 10417;
    localparam int DEF_MAX_WORD_LEN = 11;
    localparam int NUM_WORDS = 4;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_D = 8'h44;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CH_F = 8'h46;
    localparam logic [7:0] CH_G = 8'h47;
    localparam logic [7:0] CH_I = 8'h49;
    localparam logic [7:0] CH_M = 8'h4D;
    localparam logic [7:0] CH_N = 8'h4E;
    localparam logic [7:0] CH_P = 8'h50;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_S = 8'h53;
    localparam logic [7:0] CH_T = 8'h54;
    localparam logic [7:0] CH_U = 8'h55;
    localparam logic [7:0] CH_NUL = 8'h00;

    typedef enum logic [2:0] {
        WID_NONE        = 3'd0,
        WID_ENGINEERING = 3'd1,
        WID_ASSIGNMENT  = 3'd2,
        WID_STUDENT     = 3'd3,
        WID_FPGA        = 3'd4
    } word_id_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int LEN_ENGINEERING = 11;
    localparam int LEN_ASSIGNMENT  = 10;
    localparam int LEN_STUDENT     = 7;
    localparam int LEN_FPGA        = 4;

    localparam logic [0:3][3:0] WORD_LEN = '{
        4'(LEN_ENGINEERING), 4'(LEN_ASSIGNMENT),
        4'(LEN_STUDENT), 4'(LEN_FPGA)
    };

    localparam logic [0:3][0:10][7:0] WORD_TBL = '{
        '{CH_E, CH_N, CH_G, CH_I, CH_N, CH_E, CH_E, CH_R, CH_I, CH_N, CH_G},
        '{CH_A, CH_S, CH_S, CH_I, CH_G, CH_N, CH_M, CH_E, CH_N, CH_T, CH_NUL},
        '{CH_S, CH_T, CH_U, CH_D, CH_E, CH_N, CH_T,
          CH_NUL, CH_NUL, CH_NUL, CH_NUL},
        '{CH_F, CH_P, CH_G, CH_A, CH_NUL, CH_NUL, CH_NUL,
          CH_NUL, CH_NUL, CH_NUL, CH_NUL}
    };

    // Positions past the table end read as NUL, which never matches a byte
    // that reached the matcher as a letter.
    function automatic logic [7:0] word_char(
        input logic [1:0]  w,
        input int unsigned i
    );
        if (i < 11) return WORD_TBL[w][i[3:0]];
        return CH_NUL;
    endfunction

endpackage

// File: rtl/cereal_word_rx_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM,
// registered byte/valid/frame-error outputs.
module cereal_rx
    import cereal_word_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            meta_q, rx_s_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            dv_q, dv_d;
    logic            fe_q, fe_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            rx_s_q <= meta_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = HALF;
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = FULL;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s_q) begin
                    data_d  = shift_q;
                    dv_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fe_d    = 1'b1;
                    state_d = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign frame_err_o  = fe_q;

endmodule

// File: rtl/cereal_word_rx.sv
// Word receiver top: UART receiver plus a matcher that recognises
// ENGINEERING / ASSIGNMENT / STUDENT / FPGA terminated by a space.
module cereal_word_rx
    import cereal_word_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int MAX_WORD_LEN = DEF_MAX_WORD_LEN
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic [2:0] word_id,
    output logic       word_valid
);

    localparam int IDX_W = $clog2(MAX_WORD_LEN + 1);

    logic [7:0]           rx_data;
    logic                 rx_dv, rx_fe;
    logic [NUM_WORDS-1:0] alive_q, alive_d;
    logic [NUM_WORDS-1:0] hit;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 dead_q, dead_d;
    logic [2:0]           wid_q, wid_d, hit_id;
    logic                 wv_q, wv_d;

    cereal_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (sysclk),
        .rst_i       (reset),
        .rx_i        (rx),
        .data_o      (rx_data),
        .data_valid_o(rx_dv),
        .frame_err_o (rx_fe)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            alive_q <= '1;
            idx_q   <= '0;
            dead_q  <= 1'b0;
            wid_q   <= WID_NONE;
            wv_q    <= 1'b0;
        end else begin
            alive_q <= alive_d;
            idx_q   <= idx_d;
            dead_q  <= dead_d;
            wid_q   <= wid_d;
            wv_q    <= wv_d;
        end
    end

    always_comb begin
        hit    = '0;
        hit_id = WID_NONE;
        for (int w = 0; w < NUM_WORDS; w++) begin
            hit[w] = alive_q[w] && (int'(WORD_LEN[w]) == int'(idx_q));
            if (hit[w]) hit_id = 3'(w + 1);
        end
    end

    always_comb begin
        alive_d = alive_q;
        idx_d   = idx_q;
        dead_d  = dead_q;
        wid_d   = wid_q;
        wv_d    = 1'b0;
        if (rx_fe) dead_d = 1'b1;
        if (rx_dv) begin
            if (rx_data == CH_SPACE) begin
                // A lone space (empty word) is ignored entirely.
                if (idx_q != '0) begin
                    wv_d  = 1'b1;
                    wid_d = WID_NONE;
                    if (!dead_q && $onehot(hit)) wid_d = hit_id;
                end
                alive_d = '1;
                idx_d   = '0;
                dead_d  = 1'b0;
            end else begin
                for (int w = 0; w < NUM_WORDS; w++) begin
                    alive_d[w] = alive_q[w]
                        && (int'(idx_q) < int'(WORD_LEN[w]))
                        && (rx_data == word_char(2'(w), int'(idx_q)));
                end
                if (int'(idx_q) < MAX_WORD_LEN) idx_d = idx_q + 1'b1;
            end
        end
    end

    assign data       = rx_data;
    assign data_valid = rx_dv;
    assign frame_err  = rx_fe;
    assign word_id    = wid_q;
    assign word_valid = wv_q;

endmodule
